// File: rtl/p2s_pkg.sv
// p2s_pkg: shared types and defaults for the
// round-robin parallel-to-serial scheduler.
package p2s_pkg;

  typedef enum logic {
    P2S_IDLE,
    P2S_SHIFT
  } p2s_state_e;

  localparam int P2S_NUM_CH = 4;
  localparam int P2S_WIDTH  = 4;

endpackage

// File: rtl/p2s_rr_scheduler_if.sv
// p2s_rr_scheduler_if: per-channel request bus
// plus the shared serial link.
interface p2s_rr_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 4
) ();
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]       ch_enable;
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]       req_ready;
  logic                    ser_dout;
  logic                    ser_valid;
  logic                    ser_start;
  logic [CH_W-1:0]         ser_ch;
  logic                    busy;

  modport master (
    output ch_enable, req_valid, req_data,
    input  req_ready, ser_dout, ser_valid,
    input  ser_start, ser_ch, busy
  );

  modport slave (
    input  ch_enable, req_valid, req_data,
    output req_ready, ser_dout, ser_valid,
    output ser_start, ser_ch, busy
  );
endinterface

// File: rtl/p2s_shift_engine.sv
// p2s_shift_engine: WIDTH-bit MSB-first shifter
// with bit counter and frame markers.
module p2s_shift_engine #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_dout,
  output logic             ser_valid,
  output logic             ser_start,
  output logic             last
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;

  assign last     = ser_valid &&
                    (cnt == CNT_W'(WIDTH-1));
  // Zero fill drains sreg to 0 by frame end.
  assign ser_dout = sreg[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      cnt       <= '0;
      ser_valid <= 1'b0;
      ser_start <= 1'b0;
    end else begin
      ser_start <= load;
      if (load) begin
        sreg      <= load_data;
        cnt       <= '0;
        ser_valid <= 1'b1;
      end else begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
        if (last) begin
          cnt       <= '0;
          ser_valid <= 1'b0;
        end else if (ser_valid) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/p2s_rr_scheduler.sv
// p2s_rr_scheduler: round-robin grant of one
// shared serializer among NUM_CH requesters.
module p2s_rr_scheduler
  import p2s_pkg::*;
#(
  parameter int NUM_CH = P2S_NUM_CH,
  parameter int WIDTH  = P2S_WIDTH
) (
  input logic               clk,
  input logic               rst,
  p2s_rr_scheduler_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);

  p2s_state_e        state, state_nx;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   cand;
  logic [CH_W:0]     sum;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] grant;
  logic              found;
  logic              window;
  logic              xfer;
  logic              last;
  logic [WIDTH-1:0]  words [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_w
    assign words[i] = bus.req_data[i*WIDTH +: WIDTH];
  end

  assign elig = bus.req_valid & bus.ch_enable;

  // First eligible channel scanning from ptr.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH))
        sum = sum - (CH_W+1)'(NUM_CH);
      cand = sum[CH_W-1:0];
      if (!found && elig[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= P2S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      P2S_IDLE:  if (xfer) state_nx = P2S_SHIFT;
      P2S_SHIFT: if (last && !xfer)
                   state_nx = P2S_IDLE;
      default:   state_nx = P2S_IDLE;
    endcase
  end

  always_comb begin
    window        = (state == P2S_IDLE) || last;
    bus.req_ready = (window && !rst) ? grant : '0;
  end

  assign xfer = |bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      bus.ser_ch <= '0;
    end else if (xfer) begin
      bus.ser_ch <= gnt_idx;
      ptr <= (gnt_idx == CH_W'(NUM_CH-1)) ?
             '0 : gnt_idx + 1'b1;
    end
  end

  p2s_shift_engine #(.WIDTH(WIDTH)) u_eng (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer),
    .load_data (words[gnt_idx]),
    .ser_dout  (bus.ser_dout),
    .ser_valid (bus.ser_valid),
    .ser_start (bus.ser_start),
    .last      (last)
  );

  assign bus.busy = bus.ser_valid;
endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// tb_p2s_rr_scheduler: directed checks of grant
// order, framing, masking and reset.
module tb_p2s_rr_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  p2s_rr_scheduler_if #(.NUM_CH(4), .WIDTH(4)) bus ();

  p2s_rr_scheduler #(.NUM_CH(4), .WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(bus.ser_valid), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_dout"},  32'(bus.ser_dout), 0);
    chk({tag, "_start"}, 32'(bus.ser_start), 0);
    chk({tag, "_ch"},    32'(bus.ser_ch), 0);
  endtask

  logic [3:0] fw [4];
  logic [3:0] w;
  logic [3:0] b1011;
  int         ec;

  initial begin
    fw    = '{4'h8, 4'h4, 4'h2, 4'h1};
    b1011 = 4'b1011;
    bus.ch_enable = 4'hF;
    bus.req_valid = 4'hF;
    bus.req_data  = 16'h1248;

    // reset held with every channel requesting
    ticks(2);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk_idle("rst");
    bus.req_valid = '0;
    rst = 1'b0;
    tick();

    // single frame on ch2, data changed after load
    bus.req_data  = {4'h1, 4'hB, 4'h4, 4'h8};
    bus.req_valid = 4'b0100;
    #1;
    chk("sf_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    bus.req_data  = 16'h1048;
    for (int b = 0; b < 4; b++) begin
      chk("sf_dout",  32'(bus.ser_dout), 32'(b1011[3-b]));
      chk("sf_valid", 32'(bus.ser_valid), 1);
      chk("sf_start", 32'(bus.ser_start), 32'(b == 0));
      chk("sf_ch",    32'(bus.ser_ch), 2);
      tick();
    end
    chk("sf_end_valid", 32'(bus.ser_valid), 0);
    chk("sf_end_busy",  32'(bus.busy), 0);
    chk("sf_end_dout",  32'(bus.ser_dout), 0);

    // fairness: restart so ptr is 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_data  = 16'h1248;
    bus.req_valid = 4'hF;
    for (int f = 0; f < 5; f++) begin
      ec = f % 4;
      w  = fw[ec];
      #1;
      chk("rr_ready", 32'(bus.req_ready), 32'(1 << ec));
      tick();
      for (int b = 0; b < 4; b++) begin
        chk("rr_dout",  32'(bus.ser_dout), 32'(w[3-b]));
        chk("rr_valid", 32'(bus.ser_valid), 1);
        chk("rr_start", 32'(bus.ser_start), 32'(b == 0));
        chk("rr_ch",    32'(bus.ser_ch), 32'(ec));
        if (b == 1)
          chk("rr_noready", 32'(bus.req_ready), 0);
        if (b < 3) tick();
      end
      if (f == 4) bus.req_valid = '0;
    end
    tick();
    chk("rr_end_valid", 32'(bus.ser_valid), 0);
    chk("rr_end_busy",  32'(bus.busy), 0);

    // pointer rotation: ch1 then {ch0,ch3}
    bus.req_valid = 4'b0010;
    #1;
    chk("pr_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b1001;
    chk("pr_ch1", 32'(bus.ser_ch), 1);
    ticks(3);
    #1;
    chk("pr_ready3", 32'(bus.req_ready), 32'h8);
    tick();
    chk("pr_ch3",    32'(bus.ser_ch), 3);
    chk("pr_start3", 32'(bus.ser_start), 1);
    bus.req_valid = 4'b0001;
    ticks(3);
    #1;
    chk("pr_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    chk("pr_ch0", 32'(bus.ser_ch), 0);
    bus.req_valid = '0;
    ticks(4);
    chk("pr_end_busy", 32'(bus.busy), 0);

    // masking of ch1
    bus.ch_enable = 4'b1101;
    bus.req_valid = 4'b0010;
    #1;
    chk("mk_ready", 32'(bus.req_ready), 0);
    tick();
    chk("mk_busy", 32'(bus.busy), 0);
    tick();
    chk("mk_ready2", 32'(bus.req_ready), 0);
    chk("mk_busy2",  32'(bus.busy), 0);
    bus.ch_enable = 4'hF;
    #1;
    chk("mk_ready_en", 32'(bus.req_ready), 32'h2);
    tick();
    chk("mk_ch",    32'(bus.ser_ch), 1);
    chk("mk_start", 32'(bus.ser_start), 1);
    chk("mk_valid", 32'(bus.ser_valid), 1);
    bus.req_valid = '0;
    ticks(4);

    // reset mid-frame on ch2
    bus.req_data  = {4'h1, 4'hB, 4'h4, 4'h8};
    bus.req_valid = 4'b0100;
    #1;
    chk("mr_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    chk("mr_bit0", 32'(bus.ser_dout), 1);
    tick();
    chk("mr_bit1", 32'(bus.ser_dout), 0);
    chk("mr_ch",   32'(bus.ser_ch), 2);
    #2;
    rst = 1'b1;
    bus.req_valid = 4'b1001;
    #1;
    chk_idle("mr_async");
    chk("mr_async_ready", 32'(bus.req_ready), 0);
    tick();
    chk("mr_held_ready", 32'(bus.req_ready), 0);
    chk("mr_held_valid", 32'(bus.ser_valid), 0);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_post_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("mr_post_ch",    32'(bus.ser_ch), 0);
    chk("mr_post_start", 32'(bus.ser_start), 1);
    chk("mr_post_dout",  32'(bus.ser_dout), 1);
    bus.req_valid = '0;
    ticks(4);
    chk("mr_end_busy", 32'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
